// File: rtl/vx_table_sequencer_if.sv
// Shared-divider bus between the vx table sequencer and its divider.
//   div_dividend_out / div_divisor_out : operands, valid while div_valid_out is high
//   div_valid_out                      : 1-cycle request pulse to the divider
//   div_quotient_in / div_error_in     : result, qualified by div_valid_in
//   div_valid_in                       : 1-cycle result pulse from the divider
//   div_busy_in                        : divider cannot accept a request this cycle
// The master modport is the sequencer side; the slave modport is the divider side.
interface vx_table_sequencer_if #(
  parameter int DIV_W = 32
);
  logic [DIV_W-1:0] div_dividend_out;
  logic [DIV_W-1:0] div_divisor_out;
  logic             div_valid_out;
  logic [DIV_W-1:0] div_quotient_in;
  logic             div_valid_in;
  logic             div_error_in;
  logic             div_busy_in;

  modport master (
    output div_dividend_out, div_divisor_out, div_valid_out,
    input  div_quotient_in, div_valid_in, div_error_in, div_busy_in
  );

  modport slave (
    input  div_dividend_out, div_divisor_out, div_valid_out,
    output div_quotient_in, div_valid_in, div_error_in, div_busy_in
  );
endinterface

// File: rtl/vx_table_sequencer.sv
// Builds the juggling horizontal-velocity table vx[0..NUM_THROWS] through one
// shared divider. A start request latches distance and frames-per-beat, then
// throw heights p = 1..NUM_THROWS are divided one after another into a shadow
// table; all entries are committed to vx_out in a single cycle so readers never
// see a half-updated table.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   start_in           : build request (level, sampled every cycle)
//   distance_in        : right hand x minus left hand x, pixels
//   frame_per_beat_in  : frames per beat
//   div                : master side of the shared divider bus
//   vx_out             : committed velocity table, pixels/frame (entry 0 is 0)
//   table_valid_out    : a table has been committed since reset (sticky)
//   busy_out           : a sweep is in progress
//   error_out          : 1-cycle pulse at commit if any division reported error
module vx_table_sequencer #(
  parameter int S          = 20,
  parameter int NUM_THROWS = 7,
  parameter int DIV_W      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [10:0]          distance_in,
  input  logic [14:0]          frame_per_beat_in,
  vx_table_sequencer_if.master div,
  output logic [10:0]          vx_out [NUM_THROWS+1],
  output logic                 table_valid_out,
  output logic                 busy_out,
  output logic                 error_out
);

  localparam int VX_W   = 11;
  localparam int FPB_W  = 15;
  localparam int P_W    = $clog2(NUM_THROWS + 1);
  localparam int PROD_W = FPB_W + P_W;

  localparam logic [P_W-1:0]   FIRST_P       = P_W'(1);
  localparam logic [P_W-1:0]   LAST_P        = P_W'(NUM_THROWS);
  localparam logic [DIV_W-1:0] EVEN_DIVIDEND = DIV_W'(2 * S);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } state_t;

  state_t state, state_nx;

  logic [P_W-1:0]   p;
  logic             pending;
  logic             err_acc;
  logic [VX_W-1:0]  dist_q;
  logic [FPB_W-1:0] fpb_q;
  logic [VX_W-1:0]  shadow [1:NUM_THROWS];

  // Dividends never exceed 2047, so the quotient fits in the low VX_W bits.
  logic unused_quot_hi;
  assign unused_quot_hi = ^div.div_quotient_in[DIV_W-1:VX_W];

  // An erroring division contributes a zero entry rather than garbage.
  function automatic logic [VX_W-1:0] vx_from_quotient(
    input logic [VX_W-1:0] q_lo,
    input logic            err
  );
    return err ? '0 : q_lo;
  endfunction

  function automatic logic [PROD_W-1:0] divisor_of(
    input logic [P_W-1:0]   pv,
    input logic [FPB_W-1:0] f
  );
    return PROD_W'(pv) * PROD_W'(f);
  endfunction

  always_comb begin
    state_nx             = state;
    div.div_valid_out    = 1'b0;
    div.div_dividend_out = p[0] ? DIV_W'(dist_q) : EVEN_DIVIDEND;
    div.div_divisor_out  = DIV_W'(divisor_of(p, fpb_q));
    busy_out             = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start_in || pending) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!div.div_busy_in) begin
          div.div_valid_out = 1'b1;
          state_nx          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div.div_valid_in) state_nx = (p == LAST_P) ? ST_COMMIT : ST_ISSUE;
      end
      ST_COMMIT: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      p               <= '0;
      pending         <= 1'b0;
      err_acc         <= 1'b0;
      dist_q          <= '0;
      fpb_q           <= '0;
      table_valid_out <= 1'b0;
      error_out       <= 1'b0;
      for (int i = 1; i <= NUM_THROWS; i++) shadow[i] <= '0;
      for (int i = 0; i <= NUM_THROWS; i++) vx_out[i] <= '0;
    end else begin
      state     <= state_nx;
      error_out <= 1'b0;
      // Any number of requests during a sweep collapse into one follow-up sweep.
      if (start_in && (state != ST_IDLE)) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_in || pending) begin
            dist_q  <= distance_in;
            fpb_q   <= frame_per_beat_in;
            p       <= FIRST_P;
            pending <= 1'b0;
            err_acc <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (div.div_valid_in) begin
            shadow[p] <= vx_from_quotient(div.div_quotient_in[VX_W-1:0], div.div_error_in);
            err_acc   <= err_acc | div.div_error_in;
            if (p != LAST_P) p <= p + P_W'(1);
          end
        end
        ST_COMMIT: begin
          vx_out[0] <= '0;
          for (int i = 1; i <= NUM_THROWS; i++) vx_out[i] <= shadow[i];
          table_valid_out <= 1'b1;
          error_out       <= err_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_table_sequencer.sv
module tb_vx_table_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in = 1'b0;
  logic [10:0] distance = '0;
  logic [14:0] fpb = '0;
  logic [10:0] vx [8];
  logic        table_valid, busy, err;

  always #5 clk = ~clk;

  vx_table_sequencer_if #(.DIV_W(32)) dif ();

  vx_table_sequencer #(.S(20), .NUM_THROWS(7), .DIV_W(32)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .start_in          (start_in),
    .distance_in       (distance),
    .frame_per_beat_in (fpb),
    .div               (dif),
    .vx_out            (vx),
    .table_valid_out   (table_valid),
    .busy_out          (busy),
    .error_out         (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural divider with programmable latency; an injected pulse can be
  // overlaid on its result bus.
  int          lat = 1;
  logic        force_busy = 1'b0;
  logic        inj_vld = 1'b0;
  int          cnt;
  logic        m_vld, m_err, err_hold;
  logic [31:0] m_q, q_hold;

  assign dif.div_busy_in     = force_busy;
  assign dif.div_valid_in    = m_vld | inj_vld;
  assign dif.div_quotient_in = inj_vld ? 32'd99 : m_q;
  assign dif.div_error_in    = inj_vld ? 1'b0 : m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0; m_vld <= 1'b0; m_q <= '0; m_err <= 1'b0;
      q_hold <= '0; err_hold <= 1'b0;
    end else begin
      m_vld <= 1'b0;
      if (cnt == 1) begin
        m_vld <= 1'b1; m_q <= q_hold; m_err <= err_hold;
      end
      if (cnt > 0) cnt <= cnt - 1;
      if (dif.div_valid_out) begin
        cnt <= lat;
        if (dif.div_divisor_out == 0) begin
          q_hold <= '1; err_hold <= 1'b1;
        end else begin
          q_hold <= dif.div_dividend_out / dif.div_divisor_out; err_hold <= 1'b0;
        end
      end
    end
  end

  int issue_cnt = 0;
  int err_cnt   = 0;
  always @(posedge clk) begin
    if (dif.div_valid_out && !rst) issue_cnt <= issue_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  logic [10:0] tbl_a [8];  // 40/10
  logic [10:0] tbl_b [8];  // 400/30
  logic [10:0] tbl_z [8];

  function automatic bit tbl_eq(input logic [10:0] a [8], input logic [10:0] b [8]);
    for (int i = 0; i < 8; i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vx[i] !== 11'd0) $display("FAIL reset_vx[%0d]: got %0d want 0", i, vx[i]);
      else n_pass++;
    end
    n_checks++;
    if ({table_valid, busy, err, dif.div_valid_out} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {table_valid, busy, err, dif.div_valid_out});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_latency();
    int cycles = 0;
    int eb;
    bit ok;
    distance = 11'd40; fpb = 15'd10; lat = 1; eb = err_cnt;
    @(negedge clk); start_in = 1'b1;
    do begin
      @(posedge clk); cycles++; #1; start_in = 1'b0;
    end while (!table_valid && cycles < 200);
    n_checks++;
    if (cycles != 23) $display("FAIL latency: got %0d cycles want 23", cycles);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vx[i] !== tbl_a[i]) $display("FAIL basic_vx[%0d]: got %0d want %0d", i, vx[i], tbl_a[i]);
      else n_pass++;
    end
    wait_idle(50, ok);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (!ok || (err_cnt - eb) != 0 || table_valid !== 1'b1)
      $display("FAIL basic_flags: idle=%0d err_pulses=%0d valid=%b want 1/0/1", ok, err_cnt - eb, table_valid);
    else n_pass++;
  endtask

  task automatic test_ignore_stray_valid();
    @(negedge clk); inj_vld = 1'b1;
    @(negedge clk); inj_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (!tbl_eq(vx, tbl_a) || busy !== 1'b0)
      $display("FAIL stray_valid: vx1=%0d busy=%b want 4/0", vx[1], busy);
    else n_pass++;
  endtask

  task automatic test_rebuild_no_mix();
    int bad = 0;
    bit done = 1'b0;
    distance = 11'd400; fpb = 15'd30; lat = 2;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!(tbl_eq(vx, tbl_a) || tbl_eq(vx, tbl_b)) || table_valid !== 1'b1) bad++;
      if (!busy) begin done = 1'b1; break; end
    end
    n_checks++;
    if (!done || bad != 0) $display("FAIL rebuild_mix: done=%0d bad_cycles=%0d want 1/0", done, bad);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vx[i] !== tbl_b[i]) $display("FAIL rebuild_vx[%0d]: got %0d want %0d", i, vx[i], tbl_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_multi_start();
    int base = issue_cnt;
    bit done = 1'b0;
    distance = 11'd40; fpb = 15'd10; lat = 2;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (issue_cnt - base >= 2) break;
    end
    distance = 11'd400; fpb = 15'd30;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if ((issue_cnt - base) == 14 && !busy) begin done = 1'b1; break; end
    end
    repeat (30) @(posedge clk); #1;
    n_checks++;
    if (!done || (issue_cnt - base) != 14)
      $display("FAIL multi_start_issues: done=%0d got %0d want 14", done, issue_cnt - base);
    else n_pass++;
    n_checks++;
    if (!tbl_eq(vx, tbl_b) || busy !== 1'b0)
      $display("FAIL multi_start_table: vx1=%0d vx3=%0d busy=%b want 13/4/0", vx[1], vx[3], busy);
    else n_pass++;
  endtask

  task automatic test_zero_fpb();
    int eb = err_cnt;
    bit ok;
    distance = 11'd40; fpb = 15'd0; lat = 1;
    pulse_start();
    wait_idle(200, ok);
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vx[i] !== 11'd0) $display("FAIL zero_fpb_vx[%0d]: got %0d want 0", i, vx[i]);
      else n_pass++;
    end
    n_checks++;
    if (!ok || (err_cnt - eb) != 1 || table_valid !== 1'b1)
      $display("FAIL zero_fpb_err: idle=%0d err_pulses=%0d valid=%b want 1/1/1", ok, err_cnt - eb, table_valid);
    else n_pass++;
  endtask

  task automatic test_div_busy();
    int base = issue_cnt;
    int bad = 0;
    bit ok;
    distance = 11'd40; fpb = 15'd10; lat = 1; force_busy = 1'b1;
    pulse_start();
    repeat (5) begin
      @(negedge clk);
      if (dif.div_valid_out !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || (issue_cnt - base) != 0)
      $display("FAIL busy_hold: bad=%0d issues=%0d want 0/0", bad, issue_cnt - base);
    else n_pass++;
    force_busy = 1'b0;
    wait_idle(200, ok);
    n_checks++;
    if (!ok || !tbl_eq(vx, tbl_a) || (issue_cnt - base) != 7)
      $display("FAIL busy_table: idle=%0d vx1=%0d issues=%0d want 1/4/7", ok, vx[1], issue_cnt - base);
    else n_pass++;
  endtask

  task automatic test_reset_midsweep();
    int base = issue_cnt;
    bit ok;
    distance = 11'd400; fpb = 15'd30; lat = 3;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (issue_cnt - base >= 4) break;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vx[i] !== 11'd0) $display("FAIL midrst_vx[%0d]: got %0d want 0", i, vx[i]);
      else n_pass++;
    end
    n_checks++;
    if ({table_valid, busy} !== 2'b00 || (issue_cnt - base) != 4)
      $display("FAIL midrst_ctrl: valid/busy=%b issues=%0d want 00/4", {table_valid, busy}, issue_cnt - base);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    distance = 11'd40; fpb = 15'd10; lat = 1;
    pulse_start();
    wait_idle(200, ok);
    n_checks++;
    if (!ok || !tbl_eq(vx, tbl_a) || table_valid !== 1'b1)
      $display("FAIL midrst_rebuild: idle=%0d vx1=%0d valid=%b want 1/4/1", ok, vx[1], table_valid);
    else n_pass++;
  endtask

  initial begin
    tbl_a = '{11'd0, 11'd4, 11'd2, 11'd1, 11'd1, 11'd0, 11'd0, 11'd0};
    tbl_b = '{11'd0, 11'd13, 11'd0, 11'd4, 11'd0, 11'd2, 11'd0, 11'd1};
    tbl_z = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    test_reset();
    test_basic_latency();
    test_ignore_stray_valid();
    test_rebuild_no_mix();
    test_multi_start();
    test_zero_fpb();
    n_checks++;
    if (!tbl_eq(vx, tbl_z)) $display("FAIL zero_table_whole: vx1=%0d want 0", vx[1]);
    else n_pass++;
    test_div_busy();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
